// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants, state encoding and helpers for the tt_um_tpu host driver
package tpu_pkg;

   localparam int LOAD_EN_BIT      = 0;
   localparam int TRANSPOSE_BIT    = 1;
   localparam int ACTIVATION_BIT   = 2;
   localparam int ELEMWISE_BIT     = 3;
   localparam int ENABLE_BIT       = 4;
   localparam int STAT_WEIGHTS_BIT = 5;
   localparam int LOAD_WEIGHTS_BIT = 6;

   localparam int LOAD_BEATS      = 8;
   localparam int READ_BEATS_NORM = 8;
   localparam int READ_BEATS_STAT = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_WAIT = 3'd2,
      ST_READ = 3'd3,
      ST_DONE = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

   typedef struct packed {
      logic stat_weights;
      logic elemwise;
      logic activation;
      logic transpose;
   } flags_t;

   // Byte 0 of a packed operand word is the first one on the wire.
   function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/tpu_host_driver_if.sv
// rtl/tpu_host_driver_if.sv - job/result handshakes and TPU pin bundle for the host driver
interface tpu_host_driver_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_w;
   logic [31:0] cmd_x;
   logic [3:0]  cmd_flags;

   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_c;

   logic [7:0]  pin_ui_in;
   logic [7:0]  pin_uio_in;
   logic [7:0]  pin_uo_out;
   logic [7:0]  pin_uio_out;

   modport master (
      input  cmd_valid, cmd_w, cmd_x, cmd_flags, res_ready, pin_uo_out, pin_uio_out,
      output cmd_ready, res_valid, res_c, pin_ui_in, pin_uio_in
   );

   modport slave (
      output cmd_valid, cmd_w, cmd_x, cmd_flags, res_ready, pin_uo_out, pin_uio_out,
      input  cmd_ready, res_valid, res_c, pin_ui_in, pin_uio_in
   );

endinterface

// File: rtl/tpu_result_capture.sv
// rtl/tpu_result_capture.sv - writes one captured byte (normal) or halfword (stationary) into the result register
module tpu_result_capture (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_wr_en,
   input  logic        i_stat,
   input  logic [2:0]  i_beat,
   input  logic [7:0]  i_uo,
   input  logic [7:0]  i_uio,
   output logic [63:0] o_res
);

   logic [63:0] r_res;
   logic [5:0]  w_byte_lsb;
   logic [5:0]  w_half_lsb;

   // Normal mode streams each result high byte first, so even beats land in the upper byte.
   assign w_byte_lsb = {i_beat[2:1], ~i_beat[0], 3'b000};
   assign w_half_lsb = {i_beat[1:0], 4'b0000};

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_res <= '0;
      end else if (i_wr_en) begin
         if (i_stat) begin
            r_res[w_half_lsb +: 16] <= {i_uo, i_uio};
         end else begin
            r_res[w_byte_lsb +: 8] <= i_uo;
         end
      end
   end

   assign o_res = r_res;

endmodule

// File: rtl/tpu_host_driver.sv
// rtl/tpu_host_driver.sv - accepts a 2x2 job, serialises it onto the TPU pins and collects the 4 results
module tpu_host_driver
   import tpu_pkg::*;
#(
   parameter int READ_LAT = 2,
   parameter int GAP_CYC  = 1
) (
   input  logic               clk,
   input  logic               rst,
   tpu_host_driver_if.master  host
);

   localparam logic [15:0] WAIT_LAST = 16'(READ_LAT - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_beat;
   logic [2:0]  w_beat_next;
   logic [15:0] r_dly;
   logic [15:0] w_dly_next;
   logic [31:0] r_w;
   logic [31:0] r_x;
   flags_t      r_flags;

   logic        w_accept;
   logic        w_capture;
   logic [2:0]  w_read_last;
   logic [7:0]  w_ctrl;
   logic [63:0] w_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_beat  <= '0;
         r_dly   <= '0;
         r_w     <= '0;
         r_x     <= '0;
         r_flags <= '0;
      end else begin
         r_state <= w_next;
         r_beat  <= w_beat_next;
         r_dly   <= w_dly_next;
         if (w_accept) begin
            r_w     <= host.cmd_w;
            r_x     <= host.cmd_x;
            r_flags <= flags_t'(host.cmd_flags);
         end
      end
   end

   // Mode flags and enable stay on the pins for the whole load/wait/read window.
   always_comb begin
      w_ctrl                   = '0;
      w_ctrl[ENABLE_BIT]       = 1'b1;
      w_ctrl[TRANSPOSE_BIT]    = r_flags.transpose;
      w_ctrl[ACTIVATION_BIT]   = r_flags.activation;
      w_ctrl[ELEMWISE_BIT]     = r_flags.elemwise;
      w_ctrl[STAT_WEIGHTS_BIT] = r_flags.stat_weights;
   end

   assign w_read_last = r_flags.stat_weights ? 3'(READ_BEATS_STAT - 1) : 3'(READ_BEATS_NORM - 1);

   always_comb begin
      w_next          = r_state;
      w_beat_next     = r_beat;
      w_dly_next      = r_dly;
      w_accept        = 1'b0;
      w_capture       = 1'b0;
      host.cmd_ready  = 1'b0;
      host.res_valid  = 1'b0;
      host.pin_ui_in  = '0;
      host.pin_uio_in = '0;

      case (r_state)
         ST_IDLE: begin
            host.cmd_ready = 1'b1;
            if (host.cmd_valid) begin
               w_accept    = 1'b1;
               w_beat_next = '0;
               w_next      = ST_LOAD;
            end
         end

         ST_LOAD: begin
            host.pin_ui_in               = r_beat[2] ? pick_byte(r_x, r_beat[1:0])
                                                     : pick_byte(r_w, r_beat[1:0]);
            host.pin_uio_in              = w_ctrl;
            host.pin_uio_in[LOAD_EN_BIT] = 1'b1;
            host.pin_uio_in[LOAD_WEIGHTS_BIT] = r_flags.stat_weights & ~r_beat[2];
            if (r_beat == 3'(LOAD_BEATS - 1)) begin
               w_beat_next = '0;
               w_dly_next  = '0;
               w_next      = (READ_LAT == 0) ? ST_READ : ST_WAIT;
            end else begin
               w_beat_next = r_beat + 3'd1;
            end
         end

         ST_WAIT: begin
            host.pin_uio_in = w_ctrl;
            if (r_dly == WAIT_LAST) begin
               w_dly_next = '0;
               w_next     = ST_READ;
            end else begin
               w_dly_next = r_dly + 16'd1;
            end
         end

         ST_READ: begin
            host.pin_uio_in = w_ctrl;
            w_capture       = 1'b1;
            if (r_beat == w_read_last) begin
               w_beat_next = '0;
               w_next      = ST_DONE;
            end else begin
               w_beat_next = r_beat + 3'd1;
            end
         end

         ST_DONE: begin
            host.res_valid = 1'b1;
            if (host.res_ready) begin
               w_dly_next = '0;
               w_next     = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end
         end

         ST_GAP: begin
            if (r_dly == GAP_LAST) begin
               w_dly_next = '0;
               w_next     = ST_IDLE;
            end else begin
               w_dly_next = r_dly + 16'd1;
            end
         end

         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   tpu_result_capture u_capture (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_accept),
      .i_wr_en (w_capture),
      .i_stat  (r_flags.stat_weights),
      .i_beat  (r_beat),
      .i_uo    (host.pin_uo_out),
      .i_uio   (host.pin_uio_out),
      .o_res   (w_res)
   );

   assign host.res_c = w_res;

endmodule
